// File: rtl/kbd_decoder.sv
`default_nettype none
// ============================================================================
// kbd_decoder : PS/2 scan-code to ASCII decoder with show-ahead output FIFO
// Rev 1.0
// ============================================================================
module kbd_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         scan_in,
    input  logic               scan_valid,
    output logic [7:0]         ascii_out,
    output logic               ascii_valid,
    input  logic               ascii_ready,
    output logic               shift_on,
    output logic               caps_on,
    output logic [COUNT_W-1:0] key_count,
    output logic               overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               lshift_q, lshift_d, rshift_q, rshift_d;
    logic               caps_q, caps_d, caps_held_q, caps_held_d;
    logic [7:0]         last_make_q, last_make_d;
    logic               held_q, held_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic       map_hit, map_letter;
    logic [7:0] map_char, push_char;
    logic       push, pop, wr_en, full, empty;

    always_comb begin
        map_hit    = 1'b1;
        map_letter = 1'b1;
        map_char   = 8'h00;
        unique case (scan_in)
            8'h1C: map_char = 8'h61; 8'h32: map_char = 8'h62; 8'h21: map_char = 8'h63;
            8'h23: map_char = 8'h64; 8'h24: map_char = 8'h65; 8'h2B: map_char = 8'h66;
            8'h34: map_char = 8'h67; 8'h33: map_char = 8'h68; 8'h43: map_char = 8'h69;
            8'h3B: map_char = 8'h6A; 8'h42: map_char = 8'h6B; 8'h4B: map_char = 8'h6C;
            8'h3A: map_char = 8'h6D; 8'h31: map_char = 8'h6E; 8'h44: map_char = 8'h6F;
            8'h4D: map_char = 8'h70; 8'h15: map_char = 8'h71; 8'h2D: map_char = 8'h72;
            8'h1B: map_char = 8'h73; 8'h2C: map_char = 8'h74; 8'h3C: map_char = 8'h75;
            8'h2A: map_char = 8'h76; 8'h1D: map_char = 8'h77; 8'h22: map_char = 8'h78;
            8'h35: map_char = 8'h79; 8'h1A: map_char = 8'h7A;
            default: begin
                map_letter = 1'b0;
                unique case (scan_in)
                    8'h45: map_char = 8'h30; 8'h16: map_char = 8'h31; 8'h1E: map_char = 8'h32;
                    8'h26: map_char = 8'h33; 8'h25: map_char = 8'h34; 8'h2E: map_char = 8'h35;
                    8'h36: map_char = 8'h36; 8'h3D: map_char = 8'h37; 8'h3E: map_char = 8'h38;
                    8'h46: map_char = 8'h39;
                    8'h29: map_char = 8'h20; 8'h5A: map_char = 8'h0D; 8'h66: map_char = 8'h08;
                    default: map_hit = 1'b0;
                endcase
            end
        endcase
    end

    // Case comes from the registered modifier state, not this byte's effect.
    assign push_char = (map_letter && (shift_on ^ caps_q)) ? (map_char - 8'h20) : map_char;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = ascii_valid & ascii_ready;
    assign wr_en = push & (~full | pop);

    always_comb begin
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        last_make_d = last_make_q;
        held_d      = held_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        push        = 1'b0;
        if (scan_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (scan_in == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (scan_in == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (scan_in == 8'h12) begin
                        lshift_d = 1'b1;
                    end else if (scan_in == 8'h59) begin
                        rshift_d = 1'b1;
                    end else if (scan_in == 8'h58) begin
                        // Caps-lock has its own held flag so typematic repeats don't re-toggle.
                        if (!caps_held_q) caps_d = ~caps_q;
                        caps_held_d = 1'b1;
                    end else begin
                        last_make_d = scan_in;
                        held_d      = 1'b1;
                        if (map_hit) begin
                            push = 1'b1;
                            if (!(held_q && (scan_in == last_make_q)))
                                count_d = count_q + COUNT_W'(1);
                        end
                    end
                end
                S_EXT: state_d = (scan_in == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_BRK: begin
                    state_d = S_IDLE;
                    if (scan_in == 8'h12) lshift_d = 1'b0;
                    if (scan_in == 8'h59) rshift_d = 1'b0;
                    if (scan_in == 8'h58) caps_held_d = 1'b0;
                    if (scan_in == last_make_q) held_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (push && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            last_make_q <= 8'h00;
            held_q      <= 1'b0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            last_make_q <= last_make_d;
            held_q      <= held_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_char;
    end

    assign ascii_valid = ~empty;
    assign ascii_out   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign shift_on    = lshift_q | rshift_q;
    assign caps_on     = caps_q;
    assign key_count   = count_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_decoder.sv
`default_nettype none
// ============================================================================
// tb_kbd_decoder : scoreboard bench for kbd_decoder
// Rev 1.0
// ============================================================================
module tb_kbd_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_in = 8'h00;
    logic       scan_valid = 1'b0;
    logic       ascii_ready = 1'b0;
    logic [7:0] ascii_out;
    logic       ascii_valid, shift_on, caps_on, overflow;
    logic [7:0] key_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q [$];

    kbd_decoder #(.FIFO_DEPTH(4), .COUNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in     (scan_in),
        .scan_valid  (scan_valid),
        .ascii_out   (ascii_out),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .shift_on    (shift_on),
        .caps_on     (caps_on),
        .key_count   (key_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // exp < 0 means the byte must not produce a character
    task automatic send(input logic [7:0] b, input int exp);
        logic [31:0] e;
        e = exp;
        scan_in    = b;
        scan_valid = 1'b1;
        if (exp >= 0) sb_q.push_back(e[7:0]);
        step(1);
        scan_valid = 1'b0;
        scan_in    = 8'h00;
    endtask

    always @(negedge clk) begin
        if (reset && ascii_valid && ascii_ready) begin
            logic [7:0] e;
            chk("sb_avail", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("char", {24'h0, ascii_out}, {24'h0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        step(3);
        chk("rst_valid", ascii_valid, 0);
        chk("rst_out", ascii_out, 0);
        chk("rst_shift", shift_on, 0);
        chk("rst_caps", caps_on, 0);
        chk("rst_count", key_count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        step(1);

        // single key with break
        ascii_ready = 1'b1;
        send(8'h1C, 8'h61); send(8'hF0, -1); send(8'h1C, -1);
        step(2);
        chk("t1_count", key_count, 1);
        chk("t1_empty", ascii_valid, 0);
        chk("t1_sb", sb_q.size(), 0);

        // shifted and caps-locked letters
        send(8'h12, -1); send(8'h1C, 8'h41); send(8'hF0, -1); send(8'h1C, -1);
        send(8'hF0, -1); send(8'h12, -1);
        send(8'h58, -1); send(8'hF0, -1); send(8'h58, -1);
        send(8'h1C, 8'h41); send(8'hF0, -1); send(8'h1C, -1);
        step(2);
        chk("t2_shift", shift_on, 0);
        chk("t2_caps", caps_on, 1);
        chk("t2_count", key_count, 3);
        chk("t2_sb", sb_q.size(), 0);

        // caps-lock typematic repeat toggles only once
        send(8'h58, -1); send(8'h58, -1); send(8'hF0, -1); send(8'h58, -1);
        step(1);
        chk("caps_rep", caps_on, 0);

        // right shift held
        send(8'h59, -1);
        step(1);
        chk("rshift", shift_on, 1);
        send(8'hF0, -1); send(8'h59, -1);

        // typematic repeats
        send(8'h1C, 8'h61); send(8'h1C, 8'h61); send(8'h1C, 8'h61);
        send(8'hF0, -1); send(8'h1C, -1);
        step(2);
        chk("t3_count", key_count, 4);
        chk("t3_sb", sb_q.size(), 0);

        // extended make/break and unmapped keys are silent
        send(8'hE0, -1); send(8'h75, -1); send(8'hE0, -1); send(8'hF0, -1); send(8'h75, -1);
        send(8'h76, -1); send(8'hF0, -1); send(8'h76, -1);
        send(8'h16, 8'h31); send(8'hF0, -1); send(8'h16, -1);
        step(2);
        chk("t4_count", key_count, 5);
        chk("t4_sb", sb_q.size(), 0);

        // overflow: fifth character dropped, still counted
        ascii_ready = 1'b0;
        send(8'h16, 8'h31); send(8'h1E, 8'h32); send(8'h26, 8'h33);
        send(8'h25, 8'h34); send(8'h2E, -1);
        chk("t5_ovf", overflow, 1);
        chk("t5_count", key_count, 10);
        chk("t5_valid", ascii_valid, 1);
        chk("t5_head", ascii_out, 8'h31);
        ascii_ready = 1'b1;
        step(4);
        chk("t5_drained", ascii_valid, 0);
        chk("t5_sb", sb_q.size(), 0);
        chk("t5_ovf_sticky", overflow, 1);
        send(8'hF0, -1); send(8'h2E, -1);

        // reset between prefix and break byte
        ascii_ready = 1'b0;
        send(8'h16, 8'h31); send(8'hF0, -1);
        #3 reset = 1'b0;
        #1;
        chk("t6_rst_valid", ascii_valid, 0);
        chk("t6_rst_count", key_count, 0);
        chk("t6_rst_ovf", overflow, 0);
        sb_q.delete();
        step(1);
        reset = 1'b1;
        ascii_ready = 1'b1;
        send(8'h1C, 8'h61);
        step(2);
        chk("t6_count", key_count, 1);
        chk("t6_sb", sb_q.size(), 0);
        chk("t6_empty", ascii_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_decoder.md
# kbd_decoder

Converts the raw PS/2 scan-code byte stream from the `ps2` receiver into ASCII characters for the `vmem` text buffer. It tracks the make, break and extended prefixes, shift and caps-lock state, and typematic repeats. Decoded characters are buffered in a small show-ahead FIFO with a valid/ready handshake. It sits between `ps2` (`key_data`/`valid`) and `vmem` (`key_in`/`p_valid`).

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of 2 and at least 2.
- `COUNT_W`, default 8: width of the key-press counter.
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `scan_in`, in, 8: scan-code byte from the PS/2 receiver.
- `scan_valid`, in, 1: one-cycle pulse per received byte.
- `ascii_out`, out, 8: ASCII code at the FIFO head (show-ahead); 0 when the FIFO is empty.
- `ascii_valid`, out, 1: FIFO non-empty.
- `ascii_ready`, in, 1: consumer accept; a pop occurs on `ascii_valid & ascii_ready`.
- `shift_on`, out, 1: left or right shift currently held.
- `caps_on`, out, 1: caps-lock toggle state.
- `key_count`, out, `COUNT_W`: count of first-make events that produced a character; wraps modulo 2^`COUNT_W`.
- `overflow`, out, 1: sticky; set when a character is dropped because the FIFO is full.

## Operation
- **Prefix FSM:** four states, IDLE, EXT, BRK and EXT_BRK. Transitions fire only on `scan_valid`.
  - IDLE: `F0` → BRK; `E0` → EXT; any other byte is a make code and stays in IDLE.
  - EXT: `F0` → EXT_BRK; any other byte is an extended make, is discarded, and returns to IDLE.
  - BRK: the byte is the break code → IDLE.
  - EXT_BRK: the byte is an extended break, is discarded → IDLE.
- **Make handling (IDLE, non-prefix byte):**
  - `12` or `59`: set that shift flag. `shift_on` = left_flag | right_flag.
  - `58`: toggle `caps_on` on the first make only. Typematic repeats of `58` do not toggle.
  - Mapped code: push the ASCII character into the FIFO.
  - Unmapped code: ignored, no push and no count.
- **Break handling:**
  - `12` or `59`: clear that shift flag.
  - Any byte equal to `last_make`: clear `held`.
  - No output is produced on a break.
- **Typematic detection:** register `last_make[7:0]` plus `held` flag.
  - A make equal to `last_make` while `held`=1 is a repeat.
  - A repeat still pushes its character but does not increment `key_count`.
  - Any non-repeat make loads `last_make` and sets `held`.
  - Modifier keys (`12`, `59`, `58`) never load `last_make`.
- **Letter map:**
  - `1C` a, `32` b, `21` c, `23` d, `24` e, `2B` f, `34` g, `33` h, `43` i.
  - `3B` j, `42` k, `4B` l, `3A` m, `31` n, `44` o, `4D` p, `15` q, `2D` r.
  - `1B` s, `2C` t, `3C` u, `2A` v, `1D` w, `22` x, `35` y, `1A` z.
  - Output is uppercase (0x41–0x5A) when `shift_on ^ caps_on`, otherwise lowercase (0x61–0x7A).
- **Digit map (unaffected by shift and caps):**
  - `45` 0, `16` 1, `1E` 2, `26` 3, `25` 4, `2E` 5, `36` 6, `3D` 7, `3E` 8, `46` 9, giving 0x30–0x39.
- **Other keys:** `29` space → 0x20, `5A` enter → 0x0D, `66` backspace → 0x08.
- **Case source:** letter case uses the shift and caps state as registered before the current byte.
- **FIFO:** read and write pointers are `log2(FIFO_DEPTH)+1` bits wide, with MSB-differ full detection.
  - Push when full with no pop in the same cycle: the character is dropped, `overflow` is set, and `key_count` still increments for a first make.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle while empty: not possible, because a pop requires `ascii_valid`.

## Timing
- **Reset values:** while `reset`=0, all outputs are 0 and the FSM, FIFO pointers, `last_make`, `held` and shift flags are cleared. Assertion is asynchronous; release is synchronous to `clk`.
- **Reset mid-operation:** a pending prefix and any FIFO contents are lost. After release the FSM is in IDLE.
- **Latency:** `scan_valid` in cycle N produces the FIFO write at the edge ending cycle N. If the FIFO was empty, `ascii_valid` is 1 and `ascii_out` is the new character in cycle N+1.
- `shift_on`, `caps_on` and `key_count` update at the same edge, so they are visible in cycle N+1.
- **Pop:** `ascii_valid & ascii_ready` in cycle M advances the head at the edge ending M. The next entry, or `ascii_valid`=0, is visible in cycle M+1.
- **Back-to-back input:** `scan_valid` may be high on consecutive cycles; each byte is processed with no stalls.
- `ascii_ready` has no effect while `ascii_valid`=0.

## Test plan
- Reset, then bytes `1C`, `F0`, `1C` with `ascii_ready`=1 → one character 0x61, `key_count`=1, FIFO empty after the pop.
- `12`, `1C`, `F0`, `1C`, `F0`, `12`, then `58`, `F0`, `58`, then `1C` → characters 0x41 then 0x41, `shift_on`=0, `caps_on`=1.
- `1C` sent 3 times without a break → three 0x61 pushes, `key_count`=1.
- `E0`, `75`, `E0`, `F0`, `75`, then `16` → only 0x31 is output; the FSM is back in IDLE after each sequence.
- `ascii_ready`=0, then 5 mappable makes `16`, `1E`, `26`, `25`, `2E` → FIFO holds 0x31–0x34, `overflow`=1, `key_count`=5. Raising `ascii_ready` drains 0x31, 0x32, 0x33, 0x34 in order on consecutive cycles.
- Assert `reset` after `F0` and before the break byte, then after release send `1C` → 0x61 is output; the stale prefix is discarded.
